// File: rtl/selen_fetch_pkg.sv
// selen_fetch_pkg: shared fetch-stage types and constants for the SELEN pipeline.
package selen_fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: instruction-memory req/ack fetch bus.
// master = fetch controller, slave = instruction memory.
interface fetch_pc_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry parking slot for a word fetched while decode is stalled.
// kill and rel both empty the entry; kill wins over a same-cycle load.
module fetch_hold_buf
  import selen_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              rel,
  input  logic              kill,
  input  logic [31:0]       word_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [31:0]       word,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);

  // Entry register: empty on kill/release, filled on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      word  <= INSTR_NOP;
      pc    <= '0;
    end else if (kill || rel) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= word_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: SELEN fetch-stage PC controller.
// Issues one fetch at a time on the imem bus, delivers words to decode,
// and redirects/flushes on a taken M-stage branch.
// Optional build macro: SELEN_REDIRECT_CNT_EN adds the redirect_cnt output.
module fetch_pc_ctrl
  import selen_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              brnch_enM,
  input  logic              brnch_tknM,
  input  logic [ADDR_W-1:0] brnch_tgtM,
  input  logic              stallF,
  fetch_pc_ctrl_if.master   imem,
  output logic [31:0]       instrD,
  output logic [ADDR_W-1:0] pcD,
  output logic              validD,
  output logic              flush
`ifdef SELEN_REDIRECT_CNT_EN
  ,
  output logic [31:0]       redirect_cnt
`endif
);

  // state | meaning
  // ------+----------------------------------------------------------------
  // REQ   | request outstanding at pc; ack delivers, parks or is discarded
  // HOLD  | fetched word parked in hold buffer while decode stalls; no req
  // DRAIN | redirected with a fetch in flight; re-present old addr until ack

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, tgt;
  logic [ADDR_W-1:0] drain_addr, drain_addr_nxt;
  logic              redirect;
  logic [1:0]        unused_tgt_lsb;

  logic              hb_load, hb_rel, hb_kill, hb_valid;
  logic [31:0]       hb_word;
  logic [ADDR_W-1:0] hb_pc;

  logic              d_load;
  logic [31:0]       d_word;
  logic [ADDR_W-1:0] d_pc;

  assign redirect       = brnch_enM & brnch_tknM;
  assign tgt            = {brnch_tgtM[ADDR_W-1:2], 2'b00};
  assign unused_tgt_lsb = brnch_tgtM[1:0];
  assign pc_inc         = pc + ADDR_W'(PC_INC);

  assign flush          = rst_n & redirect;
  assign imem.imem_req  = rst_n & (state != HOLD);
  assign imem.imem_addr = !rst_n          ? RESET_PC   :
                          (state == DRAIN) ? drain_addr : pc;

  fetch_hold_buf #(
    .ADDR_W (ADDR_W)
  ) u_hold_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (hb_load),
    .rel     (hb_rel),
    .kill    (hb_kill),
    .word_in (imem.imem_rdata),
    .pc_in   (pc),
    .word    (hb_word),
    .pc      (hb_pc),
    .valid   (hb_valid)
  );

  // Next-state, next-pc and delivery decisions.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    hb_load        = 1'b0;
    hb_rel         = 1'b0;
    hb_kill        = 1'b0;
    d_load         = 1'b0;
    d_word         = imem.imem_rdata;
    d_pc           = pc;
    case (state)
      REQ: begin
        if (imem.imem_ack) begin
          if (redirect) begin
            pc_nxt = tgt;
          end else if (!stallF) begin
            d_load = 1'b1;
            pc_nxt = pc_inc;
          end else begin
            hb_load   = 1'b1;
            state_nxt = HOLD;
          end
        end else if (redirect) begin
          // keep presenting the in-flight address until memory acks it
          pc_nxt         = tgt;
          drain_addr_nxt = pc;
          state_nxt      = DRAIN;
        end
      end
      HOLD: begin
        if (redirect) begin
          hb_kill   = 1'b1;
          pc_nxt    = tgt;
          state_nxt = REQ;
        end else if (!stallF) begin
          hb_rel    = 1'b1;
          d_load    = hb_valid;
          d_word    = hb_word;
          d_pc      = hb_pc;
          pc_nxt    = pc_inc;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (redirect) begin
          pc_nxt = tgt;
        end
        if (imem.imem_ack) begin
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = REQ;
      end
    endcase
  end

  // State, pc and drain-address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= REQ;
      pc         <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drain_addr <= drain_addr_nxt;
    end
  end

  // Decode register: redirect kills, stall holds, otherwise load or go empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instrD <= '0;
      pcD    <= '0;
      validD <= 1'b0;
    end else if (redirect) begin
      validD <= 1'b0;
    end else if (d_load) begin
      instrD <= d_word;
      pcD    <= d_pc;
      validD <= 1'b1;
    end else if (!stallF) begin
      validD <= 1'b0;
    end
  end

`ifdef SELEN_REDIRECT_CNT_EN
  // Saturating count of redirect cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
    end else if (redirect && (redirect_cnt != 32'hFFFF_FFFF)) begin
      redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed scenarios plus a randomized run checked against
// an instruction-stream model (expected next PC, memory word function).
module tb_fetch_pc_ctrl;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0200;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        brnch_enM  = 1'b0;
  logic        brnch_tknM = 1'b0;
  logic [31:0] brnch_tgtM = '0;
  logic        stallF     = 1'b0;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        flush;
`ifdef SELEN_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_pc_ctrl_if #(.ADDR_W(ADDR_W)) imem_bus ();

  fetch_pc_ctrl #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .brnch_enM  (brnch_enM),
    .brnch_tknM (brnch_tknM),
    .brnch_tgtM (brnch_tgtM),
    .stallF     (stallF),
    .imem       (imem_bus),
    .instrD     (instrD),
    .pcD        (pcD),
    .validD     (validD),
    .flush      (flush)
`ifdef SELEN_REDIRECT_CNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    brnch_enM           = 1'b0;
    brnch_tknM          = 1'b0;
    brnch_tgtM          = '0;
    stallF              = 1'b0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic ack_now();
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
  endtask

  task automatic test_reset();
    tick();
    rst_n = 1'b0;
    idle_inputs();
    brnch_enM  = 1'b1;
    brnch_tknM = 1'b1;
    brnch_tgtM = 32'h0000_1234;
    tick();
    tick();
    #1;
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b0, RST_PC}) begin
      failures++;
      $display("FAIL reset_bus: req/addr got %b/%h expected 0/%h", imem_bus.imem_req, imem_bus.imem_addr, RST_PC);
    end
    checks++;
    if ({validD, pcD, instrD} !== {1'b0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_d: valid/pc/instr got %b/%h/%h expected 0/0/0", validD, pcD, instrD);
    end
    checks++;
    if (flush !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush: got %b expected 0", flush);
    end
    tick();
    rst_n = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, RST_PC}) begin
      failures++;
      $display("FAIL reset_cycle0: req/addr got %b/%h expected 1/%h", imem_bus.imem_req, imem_bus.imem_addr, RST_PC);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ack_now();
      #1;
      checks++;
      if ({imem_bus.imem_req, imem_bus.imem_addr} !== {1'b1, RST_PC + 32'(4 * k)}) begin
        failures++;
        $display("FAIL b2b_addr[%0d]: got %b/%h expected 1/%h", k, imem_bus.imem_req, imem_bus.imem_addr, RST_PC + 32'(4 * k));
      end
      checks++;
      if (k == 0) begin
        if (validD !== 1'b0) begin
          failures++;
          $display("FAIL b2b_first_valid: got %b expected 0", validD);
        end
      end else if ({validD, pcD, instrD} !== {1'b1, RST_PC + 32'(4 * (k - 1)), mem_word(RST_PC + 32'(4 * (k - 1)))}) begin
        failures++;
        $display("FAIL b2b_d[%0d]: got %b/%h/%h expected 1/%h", k, validD, pcD, instrD, RST_PC + 32'(4 * (k - 1)));
      end
      tick();
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    ack_now();
    tick();
    stallF = 1'b1;
    ack_now();
    #1;
    checks++;
    if ({validD, pcD, imem_bus.imem_addr} !== {1'b1, RST_PC, RST_PC + 32'h4}) begin
      failures++;
      $display("FAIL stall_c1: valid/pcD/addr got %b/%h/%h expected 1/200/204", validD, pcD, imem_bus.imem_addr);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      imem_bus.imem_ack = 1'b0;
      stallF = (k < 2);
      #1;
      checks++;
      if ({imem_bus.imem_req, validD, pcD, instrD} !== {1'b0, 1'b1, RST_PC, mem_word(RST_PC)}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: req/valid/pcD got %b/%b/%h expected 0/1/200", k, imem_bus.imem_req, validD, pcD);
      end
      tick();
    end
    stallF = 1'b0;
    #1;
    checks++;
    if ({validD, pcD, instrD, imem_bus.imem_req, imem_bus.imem_addr} !==
        {1'b1, RST_PC + 32'h4, mem_word(RST_PC + 32'h4), 1'b1, RST_PC + 32'h8}) begin
      failures++;
      $display("FAIL stall_release: valid/pcD/req/addr got %b/%h/%b/%h expected 1/204/1/208", validD, pcD, imem_bus.imem_req, imem_bus.imem_addr);
    end
    tick();
    #1;
    checks++;
    if (validD !== 1'b0) begin
      failures++;
      $display("FAIL stall_empty: validD got %b expected 0", validD);
    end
  endtask

  task automatic test_hold_redirect();
    do_reset();
    stallF = 1'b1;
    ack_now();
    tick();
    imem_bus.imem_ack = 1'b0;
    brnch_enM  = 1'b1;
    brnch_tknM = 1'b1;
    brnch_tgtM = 32'h0000_2222;
    #1;
    checks++;
    if ({flush, imem_bus.imem_req} !== 2'b10) begin
      failures++;
      $display("FAIL hold_redir_flush: flush/req got %b/%b expected 1/0", flush, imem_bus.imem_req);
    end
    tick();
    brnch_enM = 1'b0;
    #1;
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr, validD} !== {1'b1, 32'h0000_2220, 1'b0}) begin
      failures++;
      $display("FAIL hold_redir_next: req/addr/valid got %b/%h/%b expected 1/2220/0", imem_bus.imem_req, imem_bus.imem_addr, validD);
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      ack_now();
      tick();
    end
    imem_bus.imem_ack = 1'b0;
    brnch_enM  = 1'b1;
    brnch_tknM = 1'b1;
    brnch_tgtM = 32'h0000_1003;
    #1;
    checks++;
    if ({flush, imem_bus.imem_addr} !== {1'b1, 32'h0000_020C}) begin
      failures++;
      $display("FAIL drain_redir: flush/addr got %b/%h expected 1/20c", flush, imem_bus.imem_addr);
    end
    tick();
    brnch_enM = 1'b0;
    #1;
    checks++;
    if ({flush, imem_bus.imem_req, imem_bus.imem_addr, validD} !== {1'b0, 1'b1, 32'h0000_020C, 1'b0}) begin
      failures++;
      $display("FAIL drain_wait: flush/req/addr/valid got %b/%b/%h/%b expected 0/1/20c/0", flush, imem_bus.imem_req, imem_bus.imem_addr, validD);
    end
    tick();
    ack_now();
    tick();
    imem_bus.imem_ack = 1'b0;
    #1;
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr, validD} !== {1'b1, 32'h0000_1000, 1'b0}) begin
      failures++;
      $display("FAIL drain_done: req/addr/valid got %b/%h/%b expected 1/1000/0", imem_bus.imem_req, imem_bus.imem_addr, validD);
    end
    ack_now();
    tick();
    imem_bus.imem_ack = 1'b0;
    #1;
    checks++;
    if ({validD, pcD, instrD} !== {1'b1, 32'h0000_1000, mem_word(32'h0000_1000)}) begin
      failures++;
      $display("FAIL drain_target_word: valid/pcD got %b/%h expected 1/1000", validD, pcD);
    end
  endtask

  task automatic test_redirect_ack_stall();
    do_reset();
    ack_now();
    tick();
    ack_now();
    stallF     = 1'b1;
    brnch_enM  = 1'b1;
    brnch_tknM = 1'b1;
    brnch_tgtM = 32'h0000_3001;
    tick();
    idle_inputs();
    stallF = 1'b1;
    #1;
    checks++;
    if ({validD, imem_bus.imem_req, imem_bus.imem_addr} !== {1'b0, 1'b1, 32'h0000_3000}) begin
      failures++;
      $display("FAIL redir_ack_stall: valid/req/addr got %b/%b/%h expected 0/1/3000", validD, imem_bus.imem_req, imem_bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ack_now();
    brnch_enM  = 1'b1;
    brnch_tknM = 1'b1;
    brnch_tgtM = 32'hFFFF_FFFE;
    tick();
    idle_inputs();
    #1;
    checks++;
    if ({imem_bus.imem_addr, validD} !== {32'hFFFF_FFFC, 1'b0}) begin
      failures++;
      $display("FAIL wrap_top: addr/valid got %h/%b expected fffffffc/0", imem_bus.imem_addr, validD);
    end
    ack_now();
    tick();
    ack_now();
    #1;
    checks++;
    if ({imem_bus.imem_addr, validD, pcD} !== {32'h0000_0000, 1'b1, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL wrap_next: addr/valid/pcD got %h/%b/%h expected 0/1/fffffffc", imem_bus.imem_addr, validD, pcD);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ack_now();
    tick();
    imem_bus.imem_ack = 1'b0;
    brnch_enM  = 1'b1;
    brnch_tknM = 1'b1;
    brnch_tgtM = 32'h0000_5000;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr, flush} !== {1'b0, RST_PC, 1'b0}) begin
      failures++;
      $display("FAIL midrst_bus: req/addr/flush got %b/%h/%b expected 0/200/0", imem_bus.imem_req, imem_bus.imem_addr, flush);
    end
    tick();
    rst_n = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if ({imem_bus.imem_req, imem_bus.imem_addr, validD} !== {1'b1, RST_PC, 1'b0}) begin
      failures++;
      $display("FAIL midrst_restart: req/addr/valid got %b/%h/%b expected 1/200/0", imem_bus.imem_req, imem_bus.imem_addr, validD);
    end
  endtask

`ifdef SELEN_REDIRECT_CNT_EN
  task automatic test_redirect_cnt();
    do_reset();
    checks++;
    if (redirect_cnt !== 32'd0) begin
      failures++;
      $display("FAIL cnt_reset: got %0d expected 0", redirect_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      brnch_enM  = (k != 3);
      brnch_tknM = (k != 1);
      brnch_tgtM = 32'h0000_6000;
      tick();
    end
    idle_inputs();
    #1;
    checks++;
    if (redirect_cnt !== 32'd3) begin
      failures++;
      $display("FAIL cnt_three: got %0d expected 3", redirect_cnt);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_pc, maddr, tgt, prev_instr, prev_pc;
    logic        busy, redir, prev_redir, prev_hold, prev_valid;
    int          wait_cnt, consumed;
    do_reset();
    exp_pc     = RST_PC;
    maddr      = '0;
    prev_instr = '0;
    prev_pc    = '0;
    prev_valid = 1'b0;
    busy       = 1'b0;
    prev_redir = 1'b0;
    prev_hold  = 1'b0;
    wait_cnt   = 0;
    consumed   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_redir) begin
        checks++;
        if (validD !== 1'b0) begin
          failures++;
          $display("FAIL rnd_kill @%0d: validD got %b expected 0", cyc, validD);
        end
      end
      if (prev_hold) begin
        checks++;
        if ({validD, pcD, instrD} !== {prev_valid, prev_pc, prev_instr}) begin
          failures++;
          $display("FAIL rnd_stall_hold @%0d: got %b/%h/%h expected %b/%h/%h", cyc, validD, pcD, instrD, prev_valid, prev_pc, prev_instr);
        end
      end
      stallF     = ($urandom_range(0, 3) == 0);
      brnch_enM  = ($urandom_range(0, 9) == 0);
      brnch_tknM = 1'($urandom_range(0, 1));
      tgt        = 32'h0000_4000 + 32'($urandom_range(0, 4095));
      brnch_tgtM = tgt;
      redir      = brnch_enM & brnch_tknM;
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = $urandom();
      if (busy) begin
        checks++;
        if (imem_bus.imem_req !== 1'b1) begin
          failures++;
          $display("FAIL rnd_req_dropped @%0d: req got %b expected 1", cyc, imem_bus.imem_req);
          busy = 1'b0;
        end
      end
      if (imem_bus.imem_req === 1'b1) begin
        if (!busy) begin
          busy     = 1'b1;
          maddr    = imem_bus.imem_addr;
          wait_cnt = $urandom_range(0, 2);
          checks++;
          if (maddr[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL rnd_align @%0d: addr got %h expected word aligned", cyc, maddr);
          end
        end else begin
          checks++;
          if (imem_bus.imem_addr !== maddr) begin
            failures++;
            $display("FAIL rnd_addr_stable @%0d: addr got %h expected %h", cyc, imem_bus.imem_addr, maddr);
          end
        end
        if (wait_cnt == 0) begin
          imem_bus.imem_ack   = 1'b1;
          imem_bus.imem_rdata = mem_word(maddr);
          busy                = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      #1;
      checks++;
      if (flush !== redir) begin
        failures++;
        $display("FAIL rnd_flush @%0d: got %b expected %b", cyc, flush, redir);
      end
      if (validD === 1'b1 && !stallF && !redir) begin
        checks++;
        if ({pcD, instrD} !== {exp_pc, mem_word(exp_pc)}) begin
          failures++;
          $display("FAIL rnd_stream @%0d: pcD/instrD got %h/%h expected %h/%h", cyc, pcD, instrD, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redir) begin
        exp_pc = {tgt[31:2], 2'b00};
      end
      prev_redir = redir;
      prev_hold  = stallF & ~redir;
      prev_valid = validD;
      prev_pc    = pcD;
      prev_instr = instrD;
      tick();
    end
    checks++;
    if (consumed < 100) begin
      failures++;
      $display("FAIL rnd_progress: consumed got %0d expected at least 100", consumed);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_stall_hold();
    test_hold_redirect();
    test_drain();
    test_redirect_ack_stall();
    test_wrap();
    test_mid_reset();
`ifdef SELEN_REDIRECT_CNT_EN
    test_redirect_cnt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
